// File: rtl/ct_vfdsu_scalar_wb_if.sv
// rtl/ct_vfdsu_scalar_wb_if.sv - EX4-to-writeback handshake and regfile write-port bundle for the VFDSU scalar writeback buffer
interface ct_vfdsu_scalar_wb_if;
  logic        ex4_wb_vld;
  logic        ex4_wb_rdy;
  logic [63:0] ex4_out_result;
  logic [4:0]  ex4_out_expt;
  logic [6:0]  ex4_dst_vreg;
  logic [4:0]  ex4_dst_ereg;
  logic [6:0]  ex4_iid;
  logic [2:0]  ex4_fmt;
  logic        rtu_yy_xx_flush;
  logic        pipex_dp_vfdsu_wb_vld;
  logic        rf_vfdsu_wb_grant;
  logic [63:0] pipex_dp_vfdsu_freg_data;
  logic [4:0]  pipex_dp_vfdsu_ereg_data;
  logic [6:0]  pipex_dp_vfdsu_vreg;
  logic [4:0]  pipex_dp_vfdsu_ereg;
  logic [6:0]  pipex_dp_vfdsu_iid;
  logic        cp0_vfdsu_fflags_clr;
  logic [4:0]  vfdsu_fflags_acc;
  logic        vfdsu_wb_empty;

  modport master (
    output ex4_wb_vld, ex4_out_result, ex4_out_expt, ex4_dst_vreg, ex4_dst_ereg,
           ex4_iid, ex4_fmt, rtu_yy_xx_flush, rf_vfdsu_wb_grant, cp0_vfdsu_fflags_clr,
    input  ex4_wb_rdy, pipex_dp_vfdsu_wb_vld, pipex_dp_vfdsu_freg_data,
           pipex_dp_vfdsu_ereg_data, pipex_dp_vfdsu_vreg, pipex_dp_vfdsu_ereg,
           pipex_dp_vfdsu_iid, vfdsu_fflags_acc, vfdsu_wb_empty
  );

  modport slave (
    input  ex4_wb_vld, ex4_out_result, ex4_out_expt, ex4_dst_vreg, ex4_dst_ereg,
           ex4_iid, ex4_fmt, rtu_yy_xx_flush, rf_vfdsu_wb_grant, cp0_vfdsu_fflags_clr,
    output ex4_wb_rdy, pipex_dp_vfdsu_wb_vld, pipex_dp_vfdsu_freg_data,
           pipex_dp_vfdsu_ereg_data, pipex_dp_vfdsu_vreg, pipex_dp_vfdsu_ereg,
           pipex_dp_vfdsu_iid, vfdsu_fflags_acc, vfdsu_wb_empty
  );
endinterface

// File: rtl/ct_vfdsu_scalar_wb.sv
// rtl/ct_vfdsu_scalar_wb.sv - 2-entry VFDSU scalar writeback FIFO with sticky fflags accumulation
// Optional: define VFDSU_WB_NANBOX_EN to NaN-box narrow-format results as they are stored.
module ct_vfdsu_scalar_wb (
  input logic                forever_cpuclk,
  input logic                cpurst_b,
  ct_vfdsu_scalar_wb_if.slave wb
);
  logic [63:0] ent_result [2];
  logic [4:0]  ent_expt   [2];
  logic [6:0]  ent_vreg   [2];
  logic [4:0]  ent_ereg   [2];
  logic [6:0]  ent_iid    [2];

  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [4:0]  fflags_acc;
  logic        push;
  logic        pop;
  logic [63:0] push_result;

  assign push = wb.ex4_wb_vld & (count != 2'd2) & ~wb.rtu_yy_xx_flush;
  // Grant with an empty buffer is ignored because wb_vld gates the pop.
  assign pop  = (count != 2'd0) & wb.rf_vfdsu_wb_grant & ~wb.rtu_yy_xx_flush;

`ifdef VFDSU_WB_NANBOX_EN
  always_comb begin
    push_result = wb.ex4_out_result;
    case (wb.ex4_fmt)
      3'b001:         push_result = {32'hFFFF_FFFF, wb.ex4_out_result[31:0]};
      3'b010, 3'b011: push_result = {48'hFFFF_FFFF_FFFF, wb.ex4_out_result[15:0]};
      3'b100:         push_result = {56'hFF_FFFF_FFFF_FFFF, wb.ex4_out_result[7:0]};
      default:        push_result = wb.ex4_out_result;
    endcase
  end
`else
  assign push_result = wb.ex4_out_result;
`endif

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fflags_acc <= 5'd0;
      for (int i = 0; i < 2; i++) begin
        ent_result[i] <= 64'd0;
        ent_expt[i]   <= 5'd0;
        ent_vreg[i]   <= 7'd0;
        ent_ereg[i]   <= 5'd0;
        ent_iid[i]    <= 7'd0;
      end
    end else begin
      if (wb.rtu_yy_xx_flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          ent_result[wr_ptr] <= push_result;
          ent_expt[wr_ptr]   <= wb.ex4_out_expt;
          ent_vreg[wr_ptr]   <= wb.ex4_dst_vreg;
          ent_ereg[wr_ptr]   <= wb.ex4_dst_ereg;
          ent_iid[wr_ptr]    <= wb.ex4_iid;
          wr_ptr             <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
      // A clear coinciding with a pop still keeps the flags of the retiring entry.
      if (pop) begin
        fflags_acc <= (wb.cp0_vfdsu_fflags_clr ? 5'd0 : fflags_acc) | ent_expt[rd_ptr];
      end else if (wb.cp0_vfdsu_fflags_clr) begin
        fflags_acc <= 5'd0;
      end
    end
  end

  assign wb.ex4_wb_rdy               = (count != 2'd2);
  assign wb.pipex_dp_vfdsu_wb_vld    = (count != 2'd0);
  assign wb.vfdsu_wb_empty           = (count == 2'd0);
  assign wb.vfdsu_fflags_acc         = fflags_acc;
  assign wb.pipex_dp_vfdsu_freg_data = ent_result[rd_ptr];
  assign wb.pipex_dp_vfdsu_ereg_data = ent_expt[rd_ptr];
  assign wb.pipex_dp_vfdsu_vreg      = ent_vreg[rd_ptr];
  assign wb.pipex_dp_vfdsu_ereg      = ent_ereg[rd_ptr];
  assign wb.pipex_dp_vfdsu_iid       = ent_iid[rd_ptr];
endmodule
